// File: rtl/gp01_dsp_pkg.sv
// gp01_dsp_pkg: shared widths, legacy coefficients and saturation helper for the GP01 DSP chain
package gp01_dsp_pkg;
  localparam int NB_DATA_DEF  = 16;
  localparam int N_FF_DEF     = 4;
  localparam int N_FB_DEF     = 2;
  localparam int NB_SH_DEF    = 4;
  localparam int NB_GUARD_DEF = 4;
  localparam logic [N_FF_DEF-1:0]           LEGACY_FF_NEG   = 4'b0010;
  localparam logic [N_FB_DEF*NB_SH_DEF-1:0] LEGACY_FB_SHIFT = {4'd2, 4'd1};
  localparam logic [N_FB_DEF-1:0]           LEGACY_FB_NEG   = 2'b00;
  typedef struct packed {
    logic sat;
    logic hi;
  } sat_t;
  function automatic int acc_width(input int nb_data, input int nb_guard);
    return nb_data + nb_guard;
  endfunction
  function automatic int sh_lsb(input int j, input int nb_sh);
    return j * nb_sh;
  endfunction
  // sat flags an out-of-range sum; hi selects the positive clip rail over the negative one
  function automatic sat_t sat_to_width(input logic signed [63:0] acc, input int nb);
    logic signed [63:0] mx;
    sat_t r;
    mx    = (64'sd1 <<< (nb - 1)) - 64'sd1;
    r.hi  = acc > mx;
    r.sat = r.hi || (acc < -mx - 64'sd1);
    return r;
  endfunction
endpackage

// File: rtl/iir_tap_line.sv
// iir_tap_line: delay line of NB-bit words, newest word in the lowest slot
module iir_tap_line
  import gp01_dsp_pkg::*;
#(
  parameter int NB    = NB_DATA_DEF,
  parameter int DEPTH = 1
) (
  input  logic              clock,
  input  logic              i_rst_n,
  input  logic              i_en,
  input  logic              i_clr,
  input  logic [NB-1:0]     i_d,
  output logic [DEPTH*NB-1:0] o_taps
);
  logic [DEPTH*NB-1:0] r_taps;
  logic [DEPTH*NB-1:0] w_next;
  if (DEPTH == 1) begin : g_one
    assign w_next = i_d;
  end else begin : g_many
    assign w_next = {r_taps[(DEPTH-1)*NB-1:0], i_d};
  end
  // shift on enable; clear has priority over a same-cycle shift
  always_ff @(posedge clock or negedge i_rst_n) begin
    if (!i_rst_n) r_taps <= '0;
    else          r_taps <= i_clr ? '0 : (i_en ? w_next : r_taps);
  end
  assign o_taps = r_taps;
endmodule

// File: rtl/iir_shift_filter.sv
// iir_shift_filter: sign-coefficient FIR plus shift-coefficient feedback IIR with saturation
module iir_shift_filter
  import gp01_dsp_pkg::*;
#(
  parameter int NB_DATA  = NB_DATA_DEF,
  parameter int N_FF     = N_FF_DEF,
  parameter int N_FB     = N_FB_DEF,
  parameter int NB_SH    = NB_SH_DEF,
  parameter int NB_GUARD = NB_GUARD_DEF
) (
  input  logic                      clock,
  input  logic                      i_rst_n,
  input  logic                      i_valid,
  input  logic signed [NB_DATA-1:0] i_x,
  input  logic                      i_flush,
  input  logic [N_FF-1:0]           i_ff_neg,
  input  logic [N_FB*NB_SH-1:0]     i_fb_shift,
  input  logic [N_FB-1:0]           i_fb_neg,
  input  logic                      i_clr_sat,
  output logic signed [NB_DATA-1:0] o_y,
  output logic                      o_valid,
  output logic                      o_sat,
  output logic                      o_sat_sticky
);
  localparam int NB_ACC = acc_width(NB_DATA, NB_GUARD);
  localparam int N_XH   = (N_FF > 1) ? N_FF - 1 : 1;
  logic [N_XH*NB_DATA-1:0]   w_xh;
  logic [N_FB*NB_DATA-1:0]   w_yh;
  logic signed [NB_DATA-1:0] w_x [N_FF];
  logic signed [NB_DATA-1:0] w_y [N_FB];
  logic signed [NB_ACC-1:0]  w_acc;
  logic signed [NB_ACC-1:0]  w_fb;
  logic [NB_SH-1:0]          w_sh;
  sat_t                      w_sat;
  logic [NB_DATA-1:0]        w_y_new;
  logic                      w_take;
  logic signed [NB_DATA-1:0] r_y;
  logic                      r_valid;
  logic                      r_sat;
  logic                      r_sticky;
  assign w_take = i_valid & ~i_flush;
  if (N_FF > 1) begin : g_xh
    iir_tap_line #(.NB(NB_DATA), .DEPTH(N_FF - 1)) u_x_hist (
      .clock(clock), .i_rst_n(i_rst_n), .i_en(i_valid), .i_clr(i_flush),
      .i_d(i_x), .o_taps(w_xh)
    );
  end else begin : g_no_xh
    assign w_xh = '0;
  end
  iir_tap_line #(.NB(NB_DATA), .DEPTH(N_FB)) u_y_hist (
    .clock(clock), .i_rst_n(i_rst_n), .i_en(i_valid), .i_clr(i_flush),
    .i_d(w_y_new), .o_taps(w_yh)
  );
  for (genvar k = 0; k < N_FF; k++) begin : g_x
    if (k == 0) begin : g_cur
      assign w_x[k] = i_x;
    end else begin : g_old
      assign w_x[k] = w_xh[(k-1)*NB_DATA +: NB_DATA];
    end
  end
  for (genvar j = 0; j < N_FB; j++) begin : g_y
    assign w_y[j] = w_yh[j*NB_DATA +: NB_DATA];
  end
  // accumulate signed taps at guard width, then clip to the output rails
  always_comb begin
    w_acc = '0;
    w_fb  = '0;
    w_sh  = '0;
    for (int k = 0; k < N_FF; k++)
      w_acc = i_ff_neg[k] ? w_acc - NB_ACC'(w_x[k]) : w_acc + NB_ACC'(w_x[k]);
    for (int j = 0; j < N_FB; j++) begin
      w_sh  = i_fb_shift[sh_lsb(j, NB_SH) +: NB_SH];
      w_fb  = (w_sh == '0) ? NB_ACC'(0) : NB_ACC'(w_y[j]) >>> w_sh;
      w_acc = i_fb_neg[j] ? w_acc - w_fb : w_acc + w_fb;
    end
    w_sat   = sat_to_width(64'(w_acc), NB_DATA);
    w_y_new = !w_sat.sat ? w_acc[NB_DATA-1:0] :
              w_sat.hi   ? {1'b0, {(NB_DATA-1){1'b1}}} : {1'b1, {(NB_DATA-1){1'b0}}};
  end
  // output register; flush beats valid, fresh saturation beats sticky clear
  always_ff @(posedge clock or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_y      <= '0;
      r_valid  <= 1'b0;
      r_sat    <= 1'b0;
      r_sticky <= 1'b0;
    end else begin
      r_y      <= i_flush ? '0 : (i_valid ? w_y_new : r_y);
      r_valid  <= w_take;
      r_sat    <= w_take & w_sat.sat;
      r_sticky <= (w_take & w_sat.sat) | (r_sticky & ~i_clr_sat);
    end
  end
  assign o_y          = r_y;
  assign o_valid      = r_valid;
  assign o_sat        = r_sat;
  assign o_sat_sticky = r_sticky;
endmodule

// File: tb/tb_iir_shift_filter.sv
// tb_iir_shift_filter: scoreboard bench with a plain-arithmetic reference model
module tb_iir_shift_filter;
  import gp01_dsp_pkg::*;
  localparam int NB_DATA = 16, N_FF = 4, N_FB = 2, NB_SH = 4, NB_GUARD = 4;
  localparam int YMAX = 32767, YMIN = -32768;
  logic                    clock = 1'b0;
  logic                    i_rst_n = 1'b1;
  logic                    i_valid = 1'b0;
  logic signed [15:0]      i_x = '0;
  logic                    i_flush = 1'b0;
  logic [N_FF-1:0]         i_ff_neg = '0;
  logic [N_FB*NB_SH-1:0]   i_fb_shift = '0;
  logic [N_FB-1:0]         i_fb_neg = '0;
  logic                    i_clr_sat = 1'b0;
  logic signed [15:0]      o_y;
  logic                    o_valid, o_sat, o_sat_sticky;
  typedef struct {int y; int sat; int sticky;} exp_t;
  exp_t sb[$];
  exp_t mon_e;
  int xh[N_FF];
  int yh[N_FB];
  int m_sticky = 0;
  int checks = 0, failures = 0;
  int leg[5] = '{256, -128, 256, 352, 240};

  iir_shift_filter #(.NB_DATA(NB_DATA), .N_FF(N_FF), .N_FB(N_FB), .NB_SH(NB_SH), .NB_GUARD(NB_GUARD)) dut (
    .clock(clock), .i_rst_n(i_rst_n), .i_valid(i_valid), .i_x(i_x), .i_flush(i_flush),
    .i_ff_neg(i_ff_neg), .i_fb_shift(i_fb_shift), .i_fb_neg(i_fb_neg), .i_clr_sat(i_clr_sat),
    .o_y(o_y), .o_valid(o_valid), .o_sat(o_sat), .o_sat_sticky(o_sat_sticky)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0d want=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // floor(v / 2^m) done with integer division, rounding toward -inf
  function automatic int floor_shift(input int v, input int m);
    int p;
    p = 1 << m;
    return v >= 0 ? v / p : -((-v + p - 1) / p);
  endfunction

  task automatic model_clear();
    for (int k = 0; k < N_FF; k++) xh[k] = 0;
    for (int j = 0; j < N_FB; j++) yh[j] = 0;
  endtask

  task automatic step(input bit v, input int x, input bit fl, input bit clr);
    int s, t, y, sat, m;
    int cur[N_FF];
    i_valid = v; i_x = 16'(x); i_flush = fl; i_clr_sat = clr;
    y = 0; sat = 0;
    if (fl) model_clear();
    else if (v) begin
      cur[0] = x;
      for (int k = 1; k < N_FF; k++) cur[k] = xh[k];
      s = 0;
      for (int k = 0; k < N_FF; k++) s += i_ff_neg[k] ? -cur[k] : cur[k];
      for (int j = 0; j < N_FB; j++) begin
        m = int'(i_fb_shift[j*NB_SH +: NB_SH]);
        if (m != 0) begin
          t = floor_shift(yh[j], m);
          s += i_fb_neg[j] ? -t : t;
        end
      end
      y = s > YMAX ? YMAX : (s < YMIN ? YMIN : s);
      sat = (y != s) ? 1 : 0;
      for (int k = N_FF - 1; k > 1; k--) xh[k] = xh[k-1];
      xh[1] = x;
      for (int j = N_FB - 1; j > 0; j--) yh[j] = yh[j-1];
      yh[0] = y;
    end
    m_sticky = (sat != 0 || (m_sticky != 0 && !clr)) ? 1 : 0;
    if (v && !fl) sb.push_back('{y, sat, m_sticky});
    @(posedge clock);
    #1;
    i_valid = 1'b0; i_flush = 1'b0; i_clr_sat = 1'b0;
  endtask

  task automatic set_legacy();
    i_ff_neg = LEGACY_FF_NEG; i_fb_shift = LEGACY_FB_SHIFT; i_fb_neg = LEGACY_FB_NEG;
  endtask

  // monitor: every valid output is matched against the oldest queued expectation
  always @(negedge clock) begin
    if (i_rst_n) begin
      if (o_valid) begin
        if (sb.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_valid got o_y=%0d want no output", o_y);
        end else begin
          mon_e = sb.pop_front();
          chk("sb_y", int'(o_y), mon_e.y);
          chk("sb_sat", int'(o_sat), mon_e.sat);
          chk("sb_sticky", int'(o_sat_sticky), mon_e.sticky);
        end
      end else chk("idle_sat", int'(o_sat), 0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int x;
    model_clear();
    #2 i_rst_n = 1'b0;
    #2;
    chk("rst_y", int'(o_y), 0); chk("rst_valid", int'(o_valid), 0);
    chk("rst_sat", int'(o_sat), 0); chk("rst_sticky", int'(o_sat_sticky), 0);
    @(negedge clock) i_rst_n = 1'b1;
    set_legacy();
    for (int i = 0; i < 5; i++) begin
      step(1, i == 0 ? 256 : 0, 0, 0);
      chk("legacy_y", int'(o_y), leg[i]);
      chk("legacy_valid", int'(o_valid), 1);
      chk("legacy_sat", int'(o_sat), 0);
    end
    step(0, 0, 1, 0);
    chk("flush_y", int'(o_y), 0);
    i_ff_neg = '0;
    step(1, 32767, 0, 0);
    chk("sat0_y", int'(o_y), 32767); chk("sat0_flag", int'(o_sat), 0);
    step(1, 32767, 0, 0);
    chk("sat1_y", int'(o_y), 32767); chk("sat1_flag", int'(o_sat), 1);
    chk("sat1_sticky", int'(o_sat_sticky), 1);
    step(1, 32767, 0, 0);
    @(negedge clock);
    #2 i_rst_n = 1'b0;
    model_clear(); m_sticky = 0;
    #1;
    chk("arst_y", int'(o_y), 0); chk("arst_valid", int'(o_valid), 0);
    chk("arst_sat", int'(o_sat), 0); chk("arst_sticky", int'(o_sat_sticky), 0);
    @(negedge clock) i_rst_n = 1'b1;
    set_legacy();
    step(1, 256, 0, 0);
    chk("post_rst_y", int'(o_y), 256);
    for (int i = 0; i < 4; i++) step(1, 0, 0, 0);
    step(0, 0, 1, 0);
    i_ff_neg = '0;
    for (int i = 0; i < 3; i++) step(1, 32767, 0, 0);
    chk("sticky_set", int'(o_sat_sticky), 1);
    step(1, 32767, 0, 1);
    chk("sticky_collide", int'(o_sat_sticky), 1);
    step(0, 0, 0, 1);
    chk("sticky_clr", int'(o_sat_sticky), 0);
    chk("clr_hold_y", int'(o_y), 32767);
    chk("clr_valid", int'(o_valid), 0);
    step(0, 0, 1, 0);
    set_legacy();
    for (int i = 0; i < 5; i++) begin
      step(1, i == 0 ? 256 : 0, 0, 0);
      chk("gap_y", int'(o_y), leg[i]);
      step(0, 0, 0, 0);
      chk("gap_hold_y", int'(o_y), leg[i]);
      chk("gap_valid", int'(o_valid), 0);
      step(0, 0, 0, 0);
    end
    step(0, 0, 1, 0);
    i_ff_neg = '0; i_fb_shift = {4'd0, 4'd1}; i_fb_neg = 2'b01;
    step(1, -1, 0, 0);
    chk("neg_y", int'(o_y), -1);
    step(1, 0, 0, 0);
    step(0, 0, 1, 0);
    set_legacy();
    step(1, 256, 0, 0);
    step(1, 0, 0, 0);
    step(1, 0, 1, 0);
    chk("coll_valid", int'(o_valid), 0);
    chk("coll_y", int'(o_y), 0);
    step(1, 100, 0, 0);
    chk("coll_next_y", int'(o_y), 100);
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 15) == 0) begin
        i_ff_neg = 4'($urandom); i_fb_shift = 8'($urandom); i_fb_neg = 2'($urandom);
      end
      case ($urandom_range(0, 2))
        0: x = int'($urandom_range(0, 600)) - 300;
        1: x = int'($signed(16'($urandom)));
        default: x = ($urandom_range(0, 1) == 0) ? 32767 : -32768;
      endcase
      step($urandom_range(0, 3) != 0, x, $urandom_range(0, 15) == 0, $urandom_range(0, 7) == 0);
    end
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0);
    chk("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
